// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues register-file operands to a combinational ALU, writes back the result
// and returns it with the ALU flags over a valid/ready response channel.
module alu_issue_ctrl #(
    parameter int WIDTH = 2,
    parameter int NREGS = 4,
    parameter int SEL_W = 4,
    parameter int CNT_W = 8,
    localparam int RA_W = $clog2(NREGS),
    localparam int IW = SEL_W + 3 * RA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [IW-1:0]    instr,
    input  logic             reg_we,
    input  logic [RA_W-1:0]  reg_waddr,
    input  logic [WIDTH-1:0] reg_wdata,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero,
    input  logic             alu_carry,
    input  logic             alu_overflow,
    input  logic             alu_error,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_flags,
    output logic [CNT_W-1:0] ops_done
);
    localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    logic [RA_W-1:0]  rd_q, rd_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             rv_q, rv_d;
    logic [3:0]       fl_q, fl_d;
    logic [CNT_W-1:0] ops_q, ops_d;

    logic [SEL_W-1:0] i_sel;
    logic [RA_W-1:0]  i_rd, i_rs1, i_rs2;

    assign i_sel = instr[IW-1 -: SEL_W];
    assign i_rd  = instr[3*RA_W-1 -: RA_W];
    assign i_rs1 = instr[2*RA_W-1 -: RA_W];
    assign i_rs2 = instr[RA_W-1:0];

    assign instr_ready = (state_q == IDLE);
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_sel     = sel_q;
    assign rsp_valid   = rv_q;
    assign rsp_result  = res_q;
    assign rsp_flags   = fl_q;
    assign ops_done    = ops_q;

    // Operands are read from regs_q, so a host write on the accept edge is not visible to them.
    always_comb begin
        state_d = state_q;
        regs_d  = regs_q;
        rd_d    = rd_q;
        a_d     = a_q;
        b_d     = b_q;
        sel_d   = sel_q;
        rv_d    = rv_q;
        res_d   = res_q;
        fl_d    = fl_q;
        ops_d   = ops_q;
        if (state_q == IDLE) begin
            if (instr_valid) begin
                a_d     = regs_q[i_rs1];
                b_d     = regs_q[i_rs2];
                sel_d   = i_sel;
                rd_d    = i_rd;
                state_d = EXEC;
            end
            if (reg_we) regs_d[reg_waddr] = reg_wdata;
        end else if (state_q == EXEC) begin
            res_d   = alu_out;
            fl_d    = {alu_error, alu_overflow, alu_carry, alu_zero};
            rv_d    = 1'b1;
            state_d = RESP;
            if (!alu_error) regs_d[rd_q] = alu_out;
        end else if (rsp_ready) begin
            rv_d    = 1'b0;
            ops_d   = ops_q + 1'b1;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            regs_q  <= '{default: '0};
            rd_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= '0;
            rv_q    <= 1'b0;
            res_q   <= '0;
            fl_q    <= '0;
            ops_q   <= '0;
        end else begin
            state_q <= state_d;
            regs_q  <= regs_d;
            rd_q    <= rd_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            rv_q    <= rv_d;
            res_q   <= res_d;
            fl_q    <= fl_d;
            ops_q   <= ops_d;
        end
    end
endmodule
